// File: rtl/qr_pkg.sv
// Shared types and widths for the QR finder-pattern front end.
package qr_pkg;

    typedef enum logic [1:0] {IDLE, ARM, SCAN, DRAIN} scan_state_t;

    localparam int RUN_W   = 9;
    localparam int ARITH_W = 14;

    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    // Unsigned absolute difference in the comparator width.
    function automatic logic [ARITH_W-1:0] absdiff(input logic [ARITH_W-1:0] a,
                                                   input logic [ARITH_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/finder_ratio_check.sv
// Stage-2 comparator: checks five run lengths against the 1:1:3:1:1 finder ratio.
// The match flag is registered, so it appears one cycle after valid_i.
module finder_ratio_check
    import qr_pkg::*;
#(
    parameter int MIN_MODULE = 2,
    parameter int TOL_SHIFT  = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    input  logic [4:0][RUN_W-1:0]     runs_i,
    input  logic [ARITH_W-1:0]        total_i,
    output logic                      match_o
);

    logic [ARITH_W-1:0] tol;
    logic [ARITH_W-1:0] prod;
    logic [ARITH_W-1:0] ref_v;
    logic               ok;

    // Outer runs must sit near T/7 and the centre near 3T/7, within T >> TOL_SHIFT.
    always_comb begin
        tol   = total_i >> TOL_SHIFT;
        ok    = valid_i && (total_i >= ARITH_W'(7 * MIN_MODULE));
        prod  = '0;
        ref_v = '0;
        for (int i = 0; i < 5; i++) begin
            prod  = ARITH_W'(runs_i[i]) * ARITH_W'(7);
            ref_v = (i == 2) ? total_i * ARITH_W'(3) : total_i;
            if (absdiff(prod, ref_v) > tol) ok = 1'b0;
        end
    end

    // Register the verdict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) match_o <= 1'b0;
        else         match_o <= ok;
    end

endmodule

// File: rtl/finder_scan.sv
// Raster-order finder-pattern scanner. Run-length encodes each row and marks
// 1:1:3:1:1 centre runs in horz_patterns and matching rows in vert_patterns.
// Optional macro FINDER_MATCH_COUNT_EN adds a saturating match_count output.
module finder_scan
    import qr_pkg::*;
#(
    parameter int WIDTH      = 480,
    parameter int HEIGHT     = 480,
    parameter int MIN_MODULE = 2,
    parameter int TOL_SHIFT  = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_scan,
    input  logic              pixel_in,
    input  logic [RUN_W-1:0]  hcount_in,
    input  logic [RUN_W-1:0]  vcount_in,
    input  logic              valid_in,
    output logic [WIDTH-1:0]  horz_patterns,
    output logic [HEIGHT-1:0] vert_patterns,
    output logic              start_bound,
`ifdef FINDER_MATCH_COUNT_EN
    output logic [15:0]       match_count,
`endif
    output logic              busy
);

    scan_state_t state_q, state_d;
    logic        drain_q, drain_d, busy_q, busy_d, sb_q, sb_d, clr_masks;
    logic        in_rng, last_col, pix_acc, last_pix;

    // Run history: h_*[0] oldest .. h_*[3] newest completed run; cur_* is the open run.
    logic                  cur_col_q, cur_col_d;
    logic [RUN_W-1:0]      cur_len_q, cur_len_d, cur_st_q, cur_st_d;
    logic [3:0][RUN_W-1:0] h_len_q, h_len_d, h_st_q, h_st_d;
    logic [2:0]            h_cnt_q, h_cnt_d;

    logic                  cand;
    logic [4:0][RUN_W-1:0] cand_runs;
    logic [RUN_W-1:0]      cand_cs, cand_clen;
    logic [ARITH_W-1:0]    cand_t;

    logic                  s1_vld_q;
    logic [4:0][RUN_W-1:0] s1_runs_q;
    logic [ARITH_W-1:0]    s1_t_q;
    logic [RUN_W-1:0]      s1_cs_q, s1_clen_q, s1_y_q, s2_cs_q, s2_clen_q, s2_y_q;
    logic                  match;

    logic [WIDTH-1:0]      horz_q, horz_d;
    logic [HEIGHT-1:0]     vert_q, vert_d;
    logic [ARITH_W-1:0]    c_end;

    assign in_rng   = (32'(hcount_in) < WIDTH) && (32'(vcount_in) < HEIGHT);
    assign last_col = (32'(hcount_in) == WIDTH - 1);
    assign pix_acc  = valid_in && in_rng &&
                      ((state_q == SCAN) ||
                       (state_q == ARM && hcount_in == '0 && vcount_in == '0));
    assign last_pix = pix_acc && last_col && (32'(vcount_in) == HEIGHT - 1);

    // Scan sequencing: arm, scan to the last pixel, drain the 2-stage compare pipe.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        sb_d      = 1'b0;
        clr_masks = 1'b0;
        case (state_q)
            IDLE: if (start_scan) begin
                clr_masks = 1'b1;
                busy_d    = 1'b1;
                state_d   = ARM;
            end
            ARM:  if (pix_acc) state_d = SCAN;
            SCAN: if (last_pix) begin
                state_d = DRAIN;
                drain_d = 1'b0;
            end
            DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    sb_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Run tracking and candidate detection; a dark run ending after 4 runs in the row is a candidate.
    always_comb begin
        cur_col_d = cur_col_q;
        cur_len_d = cur_len_q;
        cur_st_d  = cur_st_q;
        h_len_d   = h_len_q;
        h_st_d    = h_st_q;
        h_cnt_d   = h_cnt_q;
        cand      = 1'b0;
        cand_runs = {cur_len_q, h_len_q};
        cand_cs   = h_st_q[2];
        cand_clen = h_len_q[2];
        if (pix_acc) begin
            if (hcount_in == '0) begin
                cur_col_d = pixel_in;
                cur_len_d = RUN_W'(1);
                cur_st_d  = '0;
                h_len_d   = '0;
                h_st_d    = '0;
                h_cnt_d   = '0;
            end else if (pixel_in == cur_col_q) begin
                cur_len_d = (cur_len_q == RUN_MAX) ? RUN_MAX : cur_len_q + RUN_W'(1);
            end else begin
                cand      = cur_col_q && (h_cnt_q == 3'd4);
                h_len_d   = {cur_len_q, h_len_q[3:1]};
                h_st_d    = {cur_st_q, h_st_q[3:1]};
                h_cnt_d   = (h_cnt_q == 3'd4) ? 3'd4 : h_cnt_q + 3'd1;
                cur_col_d = pixel_in;
                cur_len_d = RUN_W'(1);
                cur_st_d  = hcount_in;
            end
            // A dark run reaching the row end terminates with this pixel included.
            if (last_col && pixel_in && h_cnt_d == 3'd4) begin
                cand      = 1'b1;
                cand_runs = {cur_len_d, h_len_d};
                cand_cs   = h_st_d[2];
                cand_clen = h_len_d[2];
            end
        end
        cand_t = '0;
        for (int i = 0; i < 5; i++) cand_t = cand_t + ARITH_W'(cand_runs[i]);
    end

    // Mask accumulation: OR the matched centre span and row; cleared on arm.
    always_comb begin
        horz_d = horz_q;
        vert_d = vert_q;
        c_end  = ARITH_W'(s2_cs_q) + ARITH_W'(s2_clen_q);
        if (clr_masks) begin
            horz_d = '0;
            vert_d = '0;
        end else if (match) begin
            for (int i = 0; i < WIDTH; i++)
                if (ARITH_W'(i) >= ARITH_W'(s2_cs_q) && ARITH_W'(i) < c_end) horz_d[i] = 1'b1;
            vert_d[s2_y_q] = 1'b1;
        end
    end

    // Control, run-history and mask state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            drain_q   <= 1'b0;
            busy_q    <= 1'b0;
            sb_q      <= 1'b0;
            cur_col_q <= 1'b0;
            cur_len_q <= '0;
            cur_st_q  <= '0;
            h_len_q   <= '0;
            h_st_q    <= '0;
            h_cnt_q   <= '0;
            horz_q    <= '0;
            vert_q    <= '0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            sb_q      <= sb_d;
            cur_col_q <= cur_col_d;
            cur_len_q <= cur_len_d;
            cur_st_q  <= cur_st_d;
            h_len_q   <= h_len_d;
            h_st_q    <= h_st_d;
            h_cnt_q   <= h_cnt_d;
            horz_q    <= horz_d;
            vert_q    <= vert_d;
        end
    end

    // Stage 1 captures the candidate; its span and row ride alongside the stage-2 compare.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_vld_q  <= 1'b0;
            s1_runs_q <= '0;
            s1_t_q    <= '0;
            s1_cs_q   <= '0;
            s1_clen_q <= '0;
            s1_y_q    <= '0;
            s2_cs_q   <= '0;
            s2_clen_q <= '0;
            s2_y_q    <= '0;
        end else begin
            s1_vld_q <= cand;
            if (cand) begin
                s1_runs_q <= cand_runs;
                s1_t_q    <= cand_t;
                s1_cs_q   <= cand_cs;
                s1_clen_q <= cand_clen;
                s1_y_q    <= vcount_in;
            end
            if (s1_vld_q) begin
                s2_cs_q   <= s1_cs_q;
                s2_clen_q <= s1_clen_q;
                s2_y_q    <= s1_y_q;
            end
        end
    end

    finder_ratio_check #(
        .MIN_MODULE (MIN_MODULE),
        .TOL_SHIFT  (TOL_SHIFT)
    ) u_ratio (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .valid_i (s1_vld_q),
        .runs_i  (s1_runs_q),
        .total_i (s1_t_q),
        .match_o (match)
    );

`ifdef FINDER_MATCH_COUNT_EN
    logic [15:0] mcnt_q;

    // Per-frame count of stage-2 matches, saturating.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                         mcnt_q <= '0;
        else if (clr_masks)                  mcnt_q <= '0;
        else if (match && mcnt_q != 16'hFFFF) mcnt_q <= mcnt_q + 16'd1;
    end

    assign match_count = mcnt_q;
`endif

    assign horz_patterns = horz_q;
    assign vert_patterns = vert_q;
    assign start_bound   = sb_q;
    assign busy          = busy_q;

endmodule
